// File: rtl/radix8_digit_serializer.sv
// radix8_digit_serializer
// Splits four unsigned operand lanes into radix-8 digits, most-significant
// digit first, one digit per lane per accepted output beat.
//
// Handshake (both sides): a transfer happens on a rising edge where valid
// and ready are both 1. Once out_valid_o rises, the beat (digits, idx,
// first/last) stays stable until it is taken. in_ready_o depends
// combinationally on out_ready_i so that a new operand set can be loaded
// on the same edge that retires the last digit of the previous one.
//
// FSM state is visible externally: busy_o is 1 exactly in SHIFT.
module radix8_digit_serializer #(
    parameter  int OP_WIDTH   = 12,
    localparam int NUM_DIGITS = OP_WIDTH / 3,
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [OP_WIDTH-1:0] in_0_i,
    input  logic [OP_WIDTH-1:0] in_1_i,
    input  logic [OP_WIDTH-1:0] in_2_i,
    input  logic [OP_WIDTH-1:0] in_3_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [2:0]          digit_0_o,
    output logic [2:0]          digit_1_o,
    output logic [2:0]          digit_2_o,
    output logic [2:0]          digit_3_o,
    output logic                out_first_o,
    output logic                out_last_o,
    output logic [IDX_W-1:0]    out_idx_o,
    output logic                busy_o
);

    // Operands must split into whole digits, and need at least two of them.
    generate
        if ((OP_WIDTH % 3) != 0 || OP_WIDTH < 6) begin : g_bad_width
            $error("radix8_digit_serializer: OP_WIDTH must be a multiple of 3 and >= 6");
        end
    endgenerate

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state;
    logic [OP_WIDTH-1:0] sr [4];
    logic [IDX_W-1:0]    cnt;
    logic                valid_q;
    logic                first_q;
    logic                last_q;
    logic                accept;

    // Upstream may load when idle, or when the final digit is leaving now.
    always_comb begin
        in_ready_o = !rst_i && (state == IDLE || (valid_q && out_ready_i && last_q));
        accept     = in_valid_i && in_ready_o;
    end

    // Load / shift / retire the four lane shift registers and beat flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            valid_q <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            for (int k = 0; k < 4; k++) sr[k] <= '0;
        end else if (accept) begin
            state   <= SHIFT;
            cnt     <= '0;
            valid_q <= 1'b1;
            first_q <= 1'b1;
            last_q  <= 1'b0;
            sr[0]   <= in_0_i;
            sr[1]   <= in_1_i;
            sr[2]   <= in_2_i;
            sr[3]   <= in_3_i;
        end else if (state == SHIFT && out_ready_i) begin
            if (cnt != LAST_IDX) begin
                cnt     <= cnt + 1'b1;
                first_q <= 1'b0;
                last_q  <= ((cnt + 1'b1) == LAST_IDX);
                for (int k = 0; k < 4; k++) sr[k] <= {sr[k][OP_WIDTH-4:0], 3'b000};
            end else begin
                // Last digit taken with no follow-on set: clear so idle digits read 0.
                state   <= IDLE;
                cnt     <= '0;
                valid_q <= 1'b0;
                first_q <= 1'b0;
                last_q  <= 1'b0;
                for (int k = 0; k < 4; k++) sr[k] <= '0;
            end
        end
    end

    // Beat outputs are straight taps of the registered state.
    always_comb begin
        digit_0_o   = sr[0][OP_WIDTH-1 -: 3];
        digit_1_o   = sr[1][OP_WIDTH-1 -: 3];
        digit_2_o   = sr[2][OP_WIDTH-1 -: 3];
        digit_3_o   = sr[3][OP_WIDTH-1 -: 3];
        out_valid_o = valid_q;
        busy_o      = (state == SHIFT);
        out_idx_o   = cnt;
        out_first_o = first_q;
        out_last_o  = last_q;
    end

endmodule

// File: tb/tb_radix8_digit_serializer.sv
module tb_radix8_digit_serializer;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- 12-bit instance ----------------
  logic        in_valid, in_ready, out_valid, out_ready, out_first, out_last, busy;
  logic [11:0] in0, in1, in2, in3;
  logic [2:0]  d0, d1, d2, d3;
  logic [1:0]  out_idx;

  radix8_digit_serializer #(.OP_WIDTH(12)) u_dut12 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_0_i(in0), .in_1_i(in1), .in_2_i(in2), .in_3_i(in3),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .digit_0_o(d0), .digit_1_o(d1), .digit_2_o(d2), .digit_3_o(d3),
    .out_first_o(out_first), .out_last_o(out_last),
    .out_idx_o(out_idx), .busy_o(busy)
  );

  // ---------------- 6-bit instance ----------------
  logic       in_valid_s, in_ready_s, out_valid_s, out_ready_s, out_first_s, out_last_s, busy_s;
  logic [5:0] in0_s, in1_s, in2_s, in3_s;
  logic [2:0] d0_s, d1_s, d2_s, d3_s;
  logic [0:0] out_idx_s;

  radix8_digit_serializer #(.OP_WIDTH(6)) u_dut6 (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid_s), .in_ready_o(in_ready_s),
    .in_0_i(in0_s), .in_1_i(in1_s), .in_2_i(in2_s), .in_3_i(in3_s),
    .out_valid_o(out_valid_s), .out_ready_i(out_ready_s),
    .digit_0_o(d0_s), .digit_1_o(d1_s), .digit_2_o(d2_s), .digit_3_o(d3_s),
    .out_first_o(out_first_s), .out_last_o(out_last_s),
    .out_idx_o(out_idx_s), .busy_o(busy_s)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];   // {first, last, idx[1:0], d0, d1, d2, d3}
  logic [47:0] op_q[$];    // four 12-bit operands of each fully accepted set
  logic [23:0] op6_q[$];   // four 6-bit operands
  logic        rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected beats of a 12-bit set: digit i of x is bits [11-3i -: 3].
  task automatic push_set(input logic [11:0] a, b, c, e, input int nb);
    logic [2:0] da, db, dc, de;
    for (int i = 0; i < nb; i++) begin
      da = 3'(a >> (3 * (3 - i)));
      db = 3'(b >> (3 * (3 - i)));
      dc = 3'(c >> (3 * (3 - i)));
      de = 3'(e >> (3 * (3 - i)));
      exp_q.push_back({(i == 0), (i == 3), 2'(i), da, db, dc, de});
    end
    if (nb == 4) op_q.push_back({a, b, c, e});
  endtask

  // ---------------- driver tasks (called at posedge+1) ----------------
  task automatic send12(input logic [11:0] a, b, c, e, input int nb, output logic last_seen);
    int n = 0;
    in0 = a; in1 = b; in2 = c; in3 = e;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept12_timeout", in_ready, 1'b1);
    last_seen = out_last;
    push_set(a, b, c, e, nb);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send6(input logic [5:0] a, b, c, e);
    int n = 0;
    in0_s = a; in1_s = b; in2_s = c; in3_s = e;
    in_valid_s = 1'b1;
    @(negedge clk);
    while (!in_ready_s && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept6_timeout", in_ready_s, 1'b1);
    op6_q.push_back({a, b, c, e});
    @(posedge clk); #1;
    in_valid_s = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || busy_s) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", {busy, busy_s}, 2'b00);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, out_valid, 1'b0);
    chk({tag, "_busy"},  busy, 1'b0);
    chk({tag, "_digits"}, {d0, d1, d2, d3}, 12'h000);
    chk({tag, "_flags"}, {out_first, out_last, out_idx}, 4'h0);
  endtask

  // random backpressure in the randomized phase
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) begin
        out_ready   = 1'($urandom_range(0, 1));
        out_ready_s = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- monitor 12-bit: beat queue + accumulator ----------------
  logic [11:0] acc [4];
  logic [2:0]  dg [4];
  logic [15:0] got, e_beat;
  logic [47:0] e_op;
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      got = {out_first, out_last, out_idx, d0, d1, d2, d3};
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL beat_unexpected: got %0h expected none", got);
      end else begin
        e_beat = exp_q.pop_front();
        chk("beat12", got, e_beat);
      end
      dg[0] = d0; dg[1] = d1; dg[2] = d2; dg[3] = d3;
      for (int k = 0; k < 4; k++) acc[k] = out_first ? 12'(dg[k]) : {acc[k][8:0], dg[k]};
      if (out_last) begin
        if (op_q.size() == 0) begin
          total++; bad++;
          $display("FAIL acc12_unexpected: got %0h expected none", acc[0]);
        end else begin
          e_op = op_q.pop_front();
          for (int k = 0; k < 4; k++) chk("acc12", acc[k], e_op[47 - 12 * k -: 12]);
        end
      end
    end
  end

  // ---------------- monitor 6-bit: index tracking + accumulator ----------------
  logic [5:0]  acc6 [4];
  logic [2:0]  dg6 [4];
  logic [23:0] e_op6;
  int          beat6 = 0;
  always @(negedge clk) begin
    if (rst) begin
      beat6 = 0;
    end else if (out_valid_s && out_ready_s) begin
      chk("idx6", {out_first_s, out_last_s, out_idx_s}, {(beat6 == 0), (beat6 == 1), 1'(beat6)});
      dg6[0] = d0_s; dg6[1] = d1_s; dg6[2] = d2_s; dg6[3] = d3_s;
      for (int k = 0; k < 4; k++) acc6[k] = out_first_s ? 6'(dg6[k]) : {acc6[k][2:0], dg6[k]};
      if (out_last_s) begin
        if (op6_q.size() == 0) begin
          total++; bad++;
          $display("FAIL acc6_unexpected: got %0h expected none", acc6[0]);
        end else begin
          e_op6 = op6_q.pop_front();
          for (int k = 0; k < 4; k++) chk("acc6", acc6[k], e_op6[23 - 6 * k -: 6]);
        end
      end
      beat6 = out_last_s ? 0 : beat6 + 1;
    end
  end

  // watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random sequence ----------------
  logic ls;
  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in0 = '0; in1 = '0; in2 = '0; in3 = '0; out_ready = 1'b1;
    in_valid_s = 1'b0; in0_s = '0; in1_s = '0; in2_s = '0; in3_s = '0; out_ready_s = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b0);
    chk_idle_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // T1: single set 7531, free-running output
    send12(12'o7531, 12'o0000, 12'o0000, 12'o0000, 4, ls);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      chk("t1_in_ready", in_ready, (k == 4));
    end
    @(negedge clk);
    chk_idle_outputs("t1_idle");
    @(posedge clk); #1;

    // T2: stall three cycles on idx 1
    send12(12'o7531, 12'o0000, 12'o0000, 12'o0000, 4, ls);
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("t2_hold", {out_valid, out_idx, d0}, {1'b1, 2'd1, 3'd5});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    wait_idle();

    // T3: back-to-back sets, no bubble
    send12(12'o1234, 12'o0000, 12'o0000, 12'o0000, 4, ls);
    fork
      send12(12'o4567, 12'o0000, 12'o0000, 12'o0000, 4, ls);
      begin
        repeat (8) begin
          @(negedge clk);
          chk("t3_valid", out_valid, 1'b1);
        end
      end
    join
    chk("t3_accept_on_last", ls, 1'b1);
    wait_idle();

    // T4: independent lanes
    send12(12'o0123, 12'o4567, 12'o7777, 12'o0000, 4, ls);
    wait_idle();

    // T5: reset in the middle of a set (only idx 0,1 are taken)
    send12(12'o7531, 12'o0000, 12'o0000, 12'o0000, 2, ls);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rdy_in_rst", in_ready, 1'b0);
    chk("t5_idx_before_rst", out_idx, 2'd2);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("t5_after_rst");
    chk("t5_ready_after_rst", in_ready, 1'b1);
    @(posedge clk); #1;
    send12(12'o7531, 12'o0000, 12'o0000, 12'o0000, 4, ls);
    @(negedge clk);
    chk("t5_restart", {out_first, out_idx, d0}, {1'b1, 2'd0, 3'd7});
    @(posedge clk); #1;
    wait_idle();

    // T6: random sets with random backpressure, both widths
    rand_rdy = 1'b1;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          send12(12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom), 4, ls);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          send6(6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
      end
    join
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    out_ready_s = 1'b1;
    @(posedge clk); #1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    chk("exp_q_drained", exp_q.size(), 0);
    chk("op_q_drained", op_q.size(), 0);
    chk("op6_q_drained", op6_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
